// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: receiver FSM encoding and the scancodes
// the VGA stage reacts to.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATOS   = 2'd1,
    PARIDAD = 2'd2,
    PARADA  = 2'd3
  } estado_t;

  localparam logic [7:0] BREAK = 8'hF0;
  localparam logic [7:0] UP    = 8'h75;
  localparam logic [7:0] DO    = 8'h72;
  localparam logic [7:0] RI    = 8'h74;
  localparam logic [7:0] LE    = 8'h6B;

endpackage

// File: rtl/ps2_sync_filtro.sv
// Two-flop synchronizer plus FILTRO-deep stability filter for the PS/2 clock
// line; emits a one-cycle strobe when the filtered level falls.
module ps2_sync_filtro #(
  parameter int FILTRO = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic fall
);

  localparam int CNT_W = (FILTRO > 1) ? $clog2(FILTRO + 1) : 1;

  logic [1:0]       sync_q;
  logic             filt_q;
  logic [CNT_W-1:0] cnt_q;

  // A new level is taken only after FILTRO consecutive samples disagree with
  // the current one, so shorter glitches never reach the edge detector.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      fall   <= 1'b0;
      if (sync_q[1] != filt_q) begin
        if (cnt_q == CNT_W'(FILTRO - 1)) begin
          filt_q <= sync_q[1];
          cnt_q  <= '0;
          fall   <= filt_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_teclado_rx.sv
// PS/2 keyboard frame receiver (start, 8 data LSB first, parity, stop).
// Build option: define PS2_PARIDAD_CHECK_EN to reject frames with bad odd parity.
//
// state   | meaning
// IDLE    | waiting for a start bit (sampled 0)
// DATOS   | shifting in the 8 data bits
// PARIDAD | capturing the parity bit
// PARADA  | checking the stop bit, publishing or rejecting the byte
module ps2_teclado_rx
  import ps2_pkg::*;
#(
  parameter int FILTRO  = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] TECLADO_REG,
  output logic [7:0] TECLADO_REG_ANTERIOR,
  output logic       DATO_LISTO,
  output logic       ERROR_TRAMA
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  estado_t          state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bits_q, bits_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       reg_d, ant_d;
  logic             listo_d, error_d;
  logic [1:0]       data_sync_q;
  logic             data_s;
  logic             fall;
  logic             tmo_hit;
  logic             valido;

  ps2_sync_filtro #(.FILTRO(FILTRO)) u_clk_filtro (
    .CLK  (CLK),
    .RST  (RST),
    .din  (PS2_CLK),
    .fall (fall)
  );

  always_ff @(posedge CLK) begin
    if (!RST) data_sync_q <= 2'b11;
    else      data_sync_q <= {data_sync_q[0], PS2_DATA};
  end

  assign data_s  = data_sync_q[1];
  assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_W'(TIMEOUT - 1));

`ifdef PS2_PARIDAD_CHECK_EN
  logic par_q, par_d;

  always_ff @(posedge CLK) begin
    if (!RST) par_q <= 1'b0;
    else      par_q <= par_d;
  end

  always_comb begin
    par_d = par_q;
    if (fall && state_q == PARIDAD) par_d = data_s;
  end

  assign valido = data_s & (^{shift_q, par_q});
`else
  assign valido = data_s;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bits_d  = bits_q;
    reg_d   = TECLADO_REG;
    ant_d   = TECLADO_REG_ANTERIOR;
    listo_d = 1'b0;
    error_d = 1'b0;
    tmo_d   = tmo_q;

    // An edge in the same cycle as the timeout takes priority.
    if (fall) begin
      tmo_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d = DATOS;
            bits_d  = 3'd0;
          end
        end
        DATOS: begin
          shift_d = {data_s, shift_q[7:1]};
          bits_d  = bits_q + 3'd1;
          if (bits_q == 3'd7) state_d = PARIDAD;
        end
        PARIDAD: state_d = PARADA;
        PARADA: begin
          state_d = IDLE;
          if (valido) begin
            ant_d   = TECLADO_REG;
            reg_d   = shift_q;
            listo_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      endcase
    end else if (tmo_hit) begin
      state_d = IDLE;
      shift_d = '0;
      bits_d  = '0;
      tmo_d   = '0;
      error_d = 1'b1;
    end else if (state_q == IDLE) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q              <= IDLE;
      shift_q              <= '0;
      bits_q               <= '0;
      tmo_q                <= '0;
      TECLADO_REG          <= '0;
      TECLADO_REG_ANTERIOR <= '0;
      DATO_LISTO           <= 1'b0;
      ERROR_TRAMA          <= 1'b0;
    end else begin
      state_q              <= state_d;
      shift_q              <= shift_d;
      bits_q               <= bits_d;
      tmo_q                <= tmo_d;
      TECLADO_REG          <= reg_d;
      TECLADO_REG_ANTERIOR <= ant_d;
      DATO_LISTO           <= listo_d;
      ERROR_TRAMA          <= error_d;
    end
  end

endmodule

// File: tb/tb_ps2_teclado_rx.sv
// Directed bench for ps2_teclado_rx: frames, release codes, parity, timeout,
// glitches and mid-frame reset.
module tb_ps2_teclado_rx;

  localparam int FILTRO  = 8;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 30;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic [7:0] TECLADO_REG;
  logic [7:0] TECLADO_REG_ANTERIOR;
  logic       DATO_LISTO;
  logic       ERROR_TRAMA;

  int checks = 0;
  int errors = 0;
  int n_listo = 0;
  int n_error = 0;
  int n_ambos = 0;

  ps2_teclado_rx #(.FILTRO(FILTRO), .TIMEOUT(TIMEOUT)) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .PS2_CLK              (PS2_CLK),
    .PS2_DATA             (PS2_DATA),
    .TECLADO_REG          (TECLADO_REG),
    .TECLADO_REG_ANTERIOR (TECLADO_REG_ANTERIOR),
    .DATO_LISTO           (DATO_LISTO),
    .ERROR_TRAMA          (ERROR_TRAMA)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (DATO_LISTO) n_listo++;
    if (ERROR_TRAMA) n_error++;
    if (DATO_LISTO && ERROR_TRAMA) n_ambos++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Sends the first nbits of a frame; glitch_at >= 0 inserts a short low
  // pulse on PS2_CLK during the high phase after that bit.
  task automatic send_bits(input logic [7:0] dato, input logic par_inv,
                           input int nbits, input int glitch_at);
    logic [10:0] trama;
    trama = {1'b1, (~^dato) ^ par_inv, dato, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DATA = trama[i];
      wait_cyc(HALF / 2);
      PS2_CLK = 1'b0;
      wait_cyc(HALF);
      PS2_CLK = 1'b1;
      if (i == glitch_at) begin
        wait_cyc(4);
        PS2_CLK = 1'b0;
        wait_cyc(FILTRO - 2);
        PS2_CLK = 1'b1;
        wait_cyc(HALF / 2);
      end else begin
        wait_cyc(HALF / 2);
      end
    end
    PS2_DATA = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] dato, input logic par_inv);
    send_bits(dato, par_inv, 11, -1);
    wait_cyc(20);
  endtask

  task automatic check_regs(input string name, input logic [7:0] exp_reg,
                            input logic [7:0] exp_ant);
    checks++;
    if (TECLADO_REG !== exp_reg) begin
      errors++;
      $display("FAIL %s TECLADO_REG got=%h exp=%h", name, TECLADO_REG, exp_reg);
    end
    checks++;
    if (TECLADO_REG_ANTERIOR !== exp_ant) begin
      errors++;
      $display("FAIL %s TECLADO_REG_ANTERIOR got=%h exp=%h", name, TECLADO_REG_ANTERIOR, exp_ant);
    end
  endtask

  task automatic check_pulses(input string name, input int l0, input int e0,
                              input int exp_l, input int exp_e);
    checks++;
    if (n_listo - l0 !== exp_l) begin
      errors++;
      $display("FAIL %s DATO_LISTO cycles got=%0d exp=%0d", name, n_listo - l0, exp_l);
    end
    checks++;
    if (n_error - e0 !== exp_e) begin
      errors++;
      $display("FAIL %s ERROR_TRAMA cycles got=%0d exp=%0d", name, n_error - e0, exp_e);
    end
  endtask

  task automatic test_reset;
    RST = 1'b0;
    wait_cyc(5);
    check_regs("reset", 8'h00, 8'h00);
    checks++;
    if (DATO_LISTO !== 1'b0 || ERROR_TRAMA !== 1'b0) begin
      errors++;
      $display("FAIL reset pulses got=%b%b exp=00", DATO_LISTO, ERROR_TRAMA);
    end
    RST = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_frame;
    int l0 = n_listo, e0 = n_error;
    send_frame(8'h75, 1'b0);
    check_regs("frame_75", 8'h75, 8'h00);
    check_pulses("frame_75", l0, e0, 1, 0);
  endtask

  task automatic test_release;
    int l0 = n_listo, e0 = n_error;
    send_frame(8'h72, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h72, 1'b0);
    check_regs("release", 8'h72, 8'hF0);
    check_pulses("release", l0, e0, 3, 0);
  endtask

  task automatic test_bad_parity;
    int l0 = n_listo, e0 = n_error;
    send_frame(8'h6B, 1'b1);
`ifdef PS2_PARIDAD_CHECK_EN
    check_regs("bad_parity", 8'h72, 8'hF0);
    check_pulses("bad_parity", l0, e0, 0, 1);
`else
    check_regs("bad_parity", 8'h6B, 8'h72);
    check_pulses("bad_parity", l0, e0, 1, 0);
`endif
  endtask

  task automatic test_timeout;
    int l0 = n_listo, e0 = n_error;
    logic [7:0] prev;
    prev = TECLADO_REG;
`ifdef PS2_PARIDAD_CHECK_EN
    prev = 8'h72;
`else
    prev = 8'h6B;
`endif
    send_bits(8'h74, 1'b0, 5, -1);
    wait_cyc(TIMEOUT + 10);
    check_pulses("timeout", l0, e0, 0, 1);
    l0 = n_listo;
    e0 = n_error;
    send_frame(8'h74, 1'b0);
    check_regs("after_timeout", 8'h74, prev);
    check_pulses("after_timeout", l0, e0, 1, 0);
  endtask

  task automatic test_glitch;
    int l0 = n_listo, e0 = n_error;
    PS2_DATA = 1'b0;
    wait_cyc(5);
    PS2_CLK = 1'b0;
    wait_cyc(FILTRO - 2);
    PS2_CLK = 1'b1;
    wait_cyc(10);
    PS2_DATA = 1'b1;
    wait_cyc(20);
    send_bits(8'h75, 1'b0, 11, 4);
    wait_cyc(20);
    check_regs("glitch", 8'h75, 8'h74);
    check_pulses("glitch", l0, e0, 1, 0);
  endtask

  task automatic test_reset_mid;
    int l0, e0;
    send_bits(8'h6B, 1'b0, 6, -1);
    RST = 1'b0;
    wait_cyc(4);
    check_regs("reset_mid", 8'h00, 8'h00);
    RST = 1'b1;
    wait_cyc(20);
    l0 = n_listo;
    e0 = n_error;
    send_frame(8'h75, 1'b0);
    check_regs("after_reset_mid", 8'h75, 8'h00);
    check_pulses("after_reset_mid", l0, e0, 1, 0);
  endtask

  task automatic test_exclusive;
    checks++;
    if (n_ambos !== 0) begin
      errors++;
      $display("FAIL exclusive both_high_cycles got=%0d exp=0", n_ambos);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_release();
    test_bad_parity();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_teclado_rx.md
PS2_TECLADO_RX -- requirements
Module: ps2_teclado_rx

Interface
REQ-001 The block SHALL have parameter FILTRO, default 8, meaning the number of consecutive equal CLK samples needed to accept a new PS2_CLK level.
REQ-002 The block SHALL have parameter TIMEOUT, default 100000, meaning the number of CLK cycles without a PS2_CLK falling edge before a partial frame is abandoned.
REQ-003 The block SHALL have port CLK, input, 1 bit: the system clock, the only clock in the block.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port PS2_CLK, input, 1 bit: keyboard clock, asynchronous to CLK.
REQ-006 The block SHALL have port PS2_DATA, input, 1 bit: keyboard data, asynchronous to CLK.
REQ-007 The block SHALL have port TECLADO_REG, output, 8 bits: the last accepted scancode, feeding the VGA stage.
REQ-008 The block SHALL have port TECLADO_REG_ANTERIOR, output, 8 bits: the scancode accepted before TECLADO_REG.
REQ-009 The block SHALL have port DATO_LISTO, output, 1 bit: a one-cycle pulse per accepted frame.
REQ-010 The block SHALL have port ERROR_TRAMA, output, 1 bit: a one-cycle pulse per rejected frame (parity, stop bit or timeout).

Function
REQ-011 PS2_CLK and PS2_DATA SHALL each pass through a 2-flop synchronizer, followed by a FILTRO-deep stability filter on PS2_CLK.
REQ-012 A falling edge SHALL be detected on the filtered PS2_CLK, and PS2_DATA (synchronized) SHALL be sampled only in the CLK cycle of that edge.
REQ-013 The FSM SHALL have the states IDLE, DATOS, PARIDAD, PARADA.
REQ-014 In IDLE, a sampled bit equal to 0 (start bit) SHALL move the FSM to DATOS, and a sampled bit equal to 1 SHALL keep it in IDLE.
REQ-015 In DATOS, 8 bits SHALL be shifted in LSB first using a 3-bit counter, and the FSM SHALL move to PARIDAD after the 8th bit.
REQ-016 In PARIDAD, the parity bit SHALL be captured and the FSM SHALL move to PARADA.
REQ-017 In PARADA, the frame SHALL be valid when stop=1 and odd parity holds over data+parity; the FSM SHALL return to IDLE in every case.
REQ-018 On a valid frame, in the cycle after the stop-bit edge: TECLADO_REG_ANTERIOR<=TECLADO_REG, TECLADO_REG<=data, and DATO_LISTO=1 for exactly one cycle.
REQ-019 On an invalid frame, the outputs SHALL be unchanged and ERROR_TRAMA=1 for one cycle, with the same timing as DATO_LISTO.
REQ-020 A timeout counter SHALL be cleared on every falling edge and count while the FSM is not in IDLE; on reaching TIMEOUT-1 the FSM SHALL go to IDLE, clear the shift and bit counters, and pulse ERROR_TRAMA.
REQ-021 The timeout counter SHALL saturate, and it SHALL be held at 0 in IDLE.
REQ-022 If a falling edge and the timeout occur in the same cycle, the edge SHALL win (counter cleared, bit processed).
REQ-023 DATO_LISTO and ERROR_TRAMA SHALL never be high in the same cycle.
REQ-024 A break code (0xF0) SHALL be stored like any other byte, with no filtering of codes.

Reset
REQ-025 While RST=0 at a CLK edge: FSM=IDLE, TECLADO_REG=0x00, TECLADO_REG_ANTERIOR=0x00, DATO_LISTO=0, ERROR_TRAMA=0, all counters and the shift register 0, and synchronizer/filter state forced to 1 (line idle high).
REQ-026 Reset mid-frame SHALL discard the partial frame; the first valid start bit after reset release SHALL begin a new frame.

Configuration
REQ-027 With PS2_PARIDAD_CHECK_EN defined, a parity mismatch SHALL reject the frame per REQ-019.
REQ-028 Without PS2_PARIDAD_CHECK_EN, the parity bit SHALL be sampled and ignored, and only stop-bit and timeout errors SHALL cause rejection.

Structure
REQ-029 Package ps2_pkg SHALL hold the FSM state encoding, BREAK=8'hF0, and the arrow scancodes (UP=8'h75, DO=8'h72, RI=8'h74, LE=8'h6B) shared with the VGA stage.
REQ-030 Sub-module ps2_sync_filtro SHALL implement the synchronizer, the FILTRO-deep filter, and the falling-edge strobe, and SHALL be instantiated once for PS2_CLK.

Verification
REQ-031 Idle-to-frame: after reset, send 0x75 with correct parity -> TECLADO_REG=0x75, TECLADO_REG_ANTERIOR=0x00, one DATO_LISTO pulse.
REQ-032 Release sequence: send 0x72, 0xF0, 0x72 -> final TECLADO_REG=0x72, TECLADO_REG_ANTERIOR=0xF0, three DATO_LISTO pulses.
REQ-033 Bad parity: send 0x6B with the parity bit inverted -> with the macro, outputs unchanged and one ERROR_TRAMA pulse; without it, TECLADO_REG=0x6B.
REQ-034 Timeout: send start plus 4 data bits, then hold PS2_CLK high for TIMEOUT+10 cycles -> one ERROR_TRAMA pulse, then 0x74 sent next is received correctly.
REQ-035 Glitch: a PS2_CLK low pulse of FILTRO-2 cycles in IDLE and mid-frame -> no bit consumed, and the frame still decodes correctly.
REQ-036 Reset mid-frame: assert RST=0 after 5 data bits -> outputs 0x00, and the next full frame 0x75 is accepted.
